// File: rtl/hex_digits_scan_driver.sv
// hex_digits_scan_driver
//
// Drives a 4-digit, common-anode, time-multiplexed seven-segment display from
// the 16-bit hex-digit word written by the CPU. The word and the display mode
// bits are captured into a shadow register once per frame (at the end of the
// digit-3 slot), so a CPU write never tears a frame mid-scan.
//
// Each digit slot lasts SCAN_DIV clocks. The first BLANK_CYCLES clocks of each
// slot drive all anodes off, which prevents ghosting while the anode and
// segment lines settle on the new digit.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous, active-low reset
//   hex_value   in   [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
//   blank_lz    in   leading-zero blanking enable (digit 0 is never blanked)
//   blink_en    in   whole-display blink enable
//   seg_n       out  segments a..g on bits 0..6, active-low
//   dp_n        out  decimal point, active-low, held inactive
//   digit_en_n  out  anode enables, active-low, bit i = digit i
//   frame_tick  out  one-cycle pulse following each frame boundary
//
// Outputs are registered: they reflect the prescaler/index state of the
// previous cycle.

module hex_digits_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] hex_value,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  digit_en_n,
  output logic        frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] SLOT_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LEN  = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Scan state
  logic [PW-1:0] prescaler_reg;
  logic [1:0]    index_reg;

  // Per-frame shadow of the CPU-visible inputs
  logic [15:0]   shadow_value_reg;
  logic          shadow_lz_reg;
  logic          shadow_blink_reg;

  // Blink timing
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;

  // Registered outputs
  logic [6:0]    seg_n_reg;
  logic [3:0]    digit_en_n_reg;
  logic          frame_tick_reg;

  logic          slot_end;
  logic          frame_end;
  logic          in_blank;
  logic [3:0]    lz_hide;
  logic          visible;
  logic [3:0]    cur_nibble;
  logic [6:0]    seg_n_next;
  logic [3:0]    digit_en_n_next;

  // Hex to active-low seven-segment pattern, bit6..0 = g..a.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign slot_end  = (prescaler_reg == SLOT_LAST);
  assign frame_end = slot_end && (index_reg == 2'd3);
  assign in_blank  = (prescaler_reg < BLANK_LEN);

  // Digit i is a leading zero when it and every digit to its left are zero.
  // Digit 0 always shows, so "0000" still displays a single 0.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lz
      if (gi == 0) begin : g_units
        assign lz_hide[gi] = 1'b0;
      end else begin : g_upper
        assign lz_hide[gi] = shadow_lz_reg && (shadow_value_reg[15:4*gi] == '0);
      end
    end
  endgenerate

  assign cur_nibble = shadow_value_reg[{index_reg, 2'b00} +: 4];
  assign visible    = !(shadow_blink_reg && blink_phase_reg) && !lz_hide[index_reg];

  always_comb begin
    seg_n_next      = 7'h7F;
    digit_en_n_next = 4'hF;
    if (!in_blank && visible) begin
      seg_n_next      = decode(cur_nibble);
      digit_en_n_next = ~(4'b0001 << index_reg);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_reg    <= '0;
      index_reg        <= 2'd0;
      shadow_value_reg <= 16'h0000;
      shadow_lz_reg    <= 1'b0;
      shadow_blink_reg <= 1'b0;
      blink_cnt_reg    <= '0;
      blink_phase_reg  <= 1'b0;
      seg_n_reg        <= 7'h7F;
      digit_en_n_reg   <= 4'hF;
      frame_tick_reg   <= 1'b0;
    end else begin
      prescaler_reg <= slot_end ? '0 : prescaler_reg + 1'b1;
      if (slot_end) begin
        index_reg <= index_reg + 2'd1;
      end

      if (frame_end) begin
        shadow_value_reg <= hex_value;
        shadow_lz_reg    <= blank_lz;
        shadow_blink_reg <= blink_en;
        // The blink counter runs every frame, even while blinking is off,
        // so the phase keeps a fixed cadence relative to reset.
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end

      seg_n_reg      <= seg_n_next;
      digit_en_n_reg <= digit_en_n_next;
      frame_tick_reg <= frame_end;
    end
  end

  assign seg_n      = seg_n_reg;
  assign digit_en_n = digit_en_n_reg;
  assign frame_tick = frame_tick_reg;
  assign dp_n       = 1'b1;

endmodule
